traffic_multi: RTL and testbench

Parametrised multi-direction traffic-light controller. It is the timed successor of the two-input (power/start) single-intersection light FSM. The block sequences NDIR approaches through green, yellow and all-red phases using internal cycle timers, and accepts STR as an early-advance request that is honoured only after a minimum green time. It sits directly behind the lamp drivers; a power-down leaves the lamps dark or flashing yellow.

---
 rtl/traffic_multi.sv | 152 +++++++++++++++
 tb/tb_traffic_multi.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/traffic_multi.sv
// Timed NDIR-approach traffic-light controller: GREEN -> YELLOW -> ALLRED per approach, with STR early advance.
// Define TRAFFIC_FLASH_EN to flash all yellows while powered down instead of going dark.
module traffic_multi #(
  parameter int NDIR        = 4,
  parameter int PW          = 3,
  parameter int CW          = 8,
  parameter int GREEN_T     = 8,
  parameter int MIN_GREEN_T = 4,
  parameter int YELLOW_T    = 3,
  parameter int ALLRED_T    = 2,
  parameter int FLASH_T     = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            POW,
  input  logic            STR,
  output logic [NDIR-1:0] G,
  output logic [NDIR-1:0] Y,
  output logic [NDIR-1:0] R,
  output logic [1:0]      CURST,
  output logic [PW-1:0]   PHASE
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } state_t;

  localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] MIN_LAST    = CW'(MIN_GREEN_T - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_T - 1);
  localparam logic [PW-1:0] PHASE_LAST  = PW'(NDIR - 1);

  state_t          r_state;
  logic [PW-1:0]   r_phase;
  logic [CW-1:0]   r_cnt;
  logic [NDIR-1:0] w_onehot;

`ifdef TRAFFIC_FLASH_EN
  localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_T - 1);
  logic            r_fl;
  logic [CW-1:0]   r_fcnt;
`endif

  // Sequencer: reset, then power-down, then the normal phase walk.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_OFF;
      r_phase <= '0;
      r_cnt   <= '0;
`ifdef TRAFFIC_FLASH_EN
      r_fl    <= 1'b0;
      r_fcnt  <= '0;
`endif
    end else if (!POW) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
`ifdef TRAFFIC_FLASH_EN
      if (r_state != ST_OFF) begin
        r_fl   <= 1'b0;
        r_fcnt <= '0;
      end else if (r_fcnt == FLASH_LAST) begin
        r_fl   <= ~r_fl;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + CW'(1);
      end
`endif
    end else begin
      case (r_state)
        ST_OFF: begin
          r_state <= ST_ALLRED;
          r_phase <= '0;
          r_cnt   <= '0;
`ifdef TRAFFIC_FLASH_EN
          r_fl    <= 1'b0;
          r_fcnt  <= '0;
`endif
        end
        ST_ALLRED: begin
          if (r_cnt == ALLRED_LAST) begin
            r_state <= ST_GREEN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_GREEN: begin
          if ((r_cnt == GREEN_LAST) || (STR && (r_cnt >= MIN_LAST))) begin
            r_state <= ST_YELLOW;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_YELLOW: begin
          if (r_cnt == YELLOW_LAST) begin
            r_state <= ST_ALLRED;
            r_cnt   <= '0;
            r_phase <= (r_phase == PHASE_LAST) ? '0 : r_phase + PW'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_OFF;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_onehot = {{(NDIR-1){1'b0}}, 1'b1} << r_phase;

  // Lamp decode from registered state only.
  always_comb begin
    G = '0;
    Y = '0;
    R = '0;
    case (r_state)
      ST_GREEN: begin
        G = w_onehot;
        R = ~w_onehot;
      end
      ST_YELLOW: begin
        Y = w_onehot;
        R = ~w_onehot;
      end
      ST_ALLRED: begin
        R = '1;
      end
      default: begin
`ifdef TRAFFIC_FLASH_EN
        if (r_fl) begin
          Y = '1;
        end else begin
          Y = '0;
        end
`else
        Y = '0;
`endif
      end
    endcase
  end

  assign CURST = r_state;
  assign PHASE = r_phase;

endmodule

// File: tb/tb_traffic_multi.sv
// Directed self-checking bench for traffic_multi with default parameters.
module tb_traffic_multi;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       POW = 1'b0;
  logic       STR = 1'b0;
  logic [3:0] G, Y, R;
  logic [1:0] CURST;
  logic [2:0] PHASE;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] OFF = 2'd0, GRN = 2'd1, YEL = 2'd2, ARD = 2'd3;

  traffic_multi dut (
    .CLK(CLK), .RST(RST), .POW(POW), .STR(STR),
    .G(G), .Y(Y), .R(R), .CURST(CURST), .PHASE(PHASE)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected lamps for a powered state at a given phase (OFF without flash is all dark).
  task automatic check_state(input logic [1:0] st, input logic [2:0] ph);
    logic [3:0] oh, eg, ey, er;
    oh = 4'b0001 << ph;
    eg = 4'b0000; ey = 4'b0000; er = 4'b0000;
    case (st)
      GRN: begin eg = oh; er = ~oh; end
      YEL: begin ey = oh; er = ~oh; end
      ARD: er = 4'b1111;
      default: ;
    endcase
    check_eq("CURST", {30'd0, CURST}, {30'd0, st});
    check_eq("PHASE", {29'd0, PHASE}, {29'd0, ph});
    check_eq("G", {28'd0, G}, {28'd0, eg});
    check_eq("Y", {28'd0, Y}, {28'd0, ey});
    check_eq("R", {28'd0, R}, {28'd0, er});
  endtask

  task automatic run_state(input logic [1:0] st, input logic [2:0] ph, input int n);
    for (int i = 0; i < n; i++) begin
      check_state(st, ph);
      tick();
    end
  endtask

  initial begin
    // Reset and idle with power off
    RST = 1'b1; POW = 1'b0; STR = 1'b0;
    tick(); tick();
    check_state(OFF, 3'd0);
    RST = 1'b0;
    run_state(OFF, 3'd0, 10);

    // Power up, free-running through all four approaches
    POW = 1'b1;
    tick();
    run_state(ARD, 3'd0, 2);
    for (int p = 0; p < 4; p++) begin
      run_state(GRN, 3'(p), 8);
      run_state(YEL, 3'(p), 3);
      run_state(ARD, 3'((p + 1) % 4), 2);
    end
    check_eq("G_wrap", {28'd0, G}, 32'h1);

    // STR held from green entry: green lasts MIN_GREEN_T
    STR = 1'b1;
    run_state(GRN, 3'd0, 4);
    STR = 1'b0;
    run_state(YEL, 3'd0, 3);
    run_state(ARD, 3'd1, 2);

    // STR pulse at green cycle 2 is too early
    run_state(GRN, 3'd1, 2);
    STR = 1'b1;
    run_state(GRN, 3'd1, 1);
    STR = 1'b0;
    run_state(GRN, 3'd1, 5);
    run_state(YEL, 3'd1, 3);
    run_state(ARD, 3'd2, 2);

    // STR pulse at green cycle 5 ends green immediately
    run_state(GRN, 3'd2, 5);
    STR = 1'b1;
    run_state(GRN, 3'd2, 1);
    STR = 1'b0;
    run_state(YEL, 3'd2, 1);

    // Power-down mid-yellow at phase 2
    POW = 1'b0;
    tick();
    check_state(OFF, 3'd2);
`ifdef TRAFFIC_FLASH_EN
    for (int i = 0; i < 30; i++) begin
      check_eq("FLASH_Y", {28'd0, Y}, (((i / 5) % 2) == 1) ? 32'hF : 32'h0);
      check_eq("FLASH_G", {28'd0, G}, 32'h0);
      check_eq("FLASH_R", {28'd0, R}, 32'h0);
      tick();
    end
`else
    run_state(OFF, 3'd2, 10);
`endif

    // Power back up restarts at phase 0
    POW = 1'b1;
    tick();
    run_state(ARD, 3'd0, 2);
    run_state(GRN, 3'd0, 8);
    run_state(YEL, 3'd0, 3);
    run_state(ARD, 3'd1, 2);
    run_state(GRN, 3'd1, 2);

    // Reset beats concurrent POW and STR in mid-green
    RST = 1'b1; POW = 1'b1; STR = 1'b1;
    tick();
    check_state(OFF, 3'd0);
    RST = 1'b0; STR = 1'b0;
    tick();
    check_state(ARD, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
